// File: rtl/punchout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : punchout_pkg
// Purpose  : Shared constants, colours and drawer FSM encoding for the game.
// Revision : 1.0
// ============================================================================
package punchout_pkg;

    localparam logic [7:0] X_LEFT  = 8'd20;
    localparam logic [7:0] X_MID   = 8'd60;
    localparam logic [7:0] X_RIGHT = 8'd100;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOUR_BG     = 3'b000;
    localparam logic [2:0] COLOUR_BODY   = 3'b100;
    localparam logic [2:0] COLOUR_ATTACK = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ERASE  = 2'd1,
        ST_DRAW   = 2'd2,
        ST_FINISH = 2'd3
    } drawer_state_t;

    // Position code 0 means "no position" and decodes to column 0.
    function automatic logic [7:0] decode_x(input logic [1:0] code);
        logic [7:0] x;
        case (code)
            2'd1:    x = X_LEFT;
            2'd2:    x = X_MID;
            2'd3:    x = X_RIGHT;
            default: x = 8'd0;
        endcase
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_sprite_drawer_if.sv
`default_nettype none
// ============================================================================
// Module   : enemy_sprite_drawer_if
// Purpose  : Update request from the enemy controller and pixel port to VGA.
// Revision : 1.0
// ============================================================================
interface enemy_sprite_drawer_if;

    logic       update;
    logic [1:0] x_pos;
    logic       attack;
    logic       dead;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output update, x_pos, attack, dead,
        input  vga_x, vga_y, colour, plot, busy, done
    );

    modport slave (
        input  update, x_pos, attack, dead,
        output vga_x, vga_y, colour, plot, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/enemy_sprite_drawer_box_scanner.sv
`default_nettype none
// ============================================================================
// Module   : box_scanner
// Purpose  : Column-fastest raster counter over a SPRITE_W x SPRITE_H box.
// Revision : 1.0
// ============================================================================
module box_scanner #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 24,
    parameter int COL_W    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
    parameter int ROW_W    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic             step,
    output logic      [COL_W-1:0] col,
    output logic      [ROW_W-1:0] row,
    output logic                  last
);

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(SPRITE_H - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Stepping past the last pixel wraps to 0,0 so DRAW can follow ERASE directly.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (step) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign last = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

endmodule
`default_nettype wire

// File: rtl/enemy_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : enemy_sprite_drawer
// Purpose  : Erases the enemy's previous box then draws the new pose, one pixel per clock.
// Revision : 1.0
// ============================================================================
module enemy_sprite_drawer
    import punchout_pkg::*;
#(
    parameter int         SPRITE_W      = 16,
    parameter int         SPRITE_H      = 24,
    parameter int         Y_TOP         = 8,
    parameter logic [2:0] BG_COLOUR     = COLOUR_BG,
    parameter logic [2:0] BODY_COLOUR   = COLOUR_BODY,
    parameter logic [2:0] ATTACK_COLOUR = COLOUR_ATTACK
) (
    input wire logic             clock,
    input wire logic             reset,
    enemy_sprite_drawer_if.slave bus
);

    localparam int c_COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int c_ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    drawer_state_t      r_state;
    logic               r_pending;
    logic               r_prev_valid;
    logic [7:0]         r_prev_x;
    logic [7:0]         r_new_x;
    logic               r_new_valid;
    logic               r_new_attack;
    logic               r_new_dead;

    logic [7:0]         r_vga_x;
    logic [6:0]         r_vga_y;
    logic [2:0]         r_colour;
    logic               r_plot;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_step;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    logic               w_last;

    assign w_accept = (r_state == ST_IDLE) && (bus.update || r_pending);
    assign w_step   = (r_state == ST_ERASE) || (r_state == ST_DRAW);

    box_scanner #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .COL_W    (c_COL_W),
        .ROW_W    (c_ROW_W)
    ) u_scanner (
        .clock (clock),
        .reset (reset),
        .start (w_accept),
        .step  (w_step),
        .col   (w_col),
        .row   (w_row),
        .last  (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_prev_valid <= 1'b0;
            r_prev_x     <= 8'd0;
            r_new_x      <= 8'd0;
            r_new_valid  <= 1'b0;
            r_new_attack <= 1'b0;
            r_new_dead   <= 1'b0;
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_colour     <= 3'd0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            r_busy <= (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_new_x      <= decode_x(bus.x_pos);
                        r_new_valid  <= (bus.x_pos != 2'd0);
                        r_new_attack <= bus.attack;
                        r_new_dead   <= bus.dead;
                        r_pending    <= 1'b0;
                        if (r_prev_valid)
                            r_state <= ST_ERASE;
                        else if ((bus.x_pos != 2'd0) && !bus.dead)
                            r_state <= ST_DRAW;
                        else
                            r_state <= ST_FINISH;
                    end
                end

                ST_ERASE: begin
                    r_plot   <= 1'b1;
                    r_vga_x  <= r_prev_x + 8'(w_col);
                    r_vga_y  <= 7'(Y_TOP) + 7'(w_row);
                    r_colour <= BG_COLOUR;
                    if (w_last)
                        r_state <= (r_new_valid && !r_new_dead) ? ST_DRAW : ST_FINISH;
                end

                ST_DRAW: begin
                    r_plot   <= 1'b1;
                    r_vga_x  <= r_new_x + 8'(w_col);
                    r_vga_y  <= 7'(Y_TOP) + 7'(w_row);
                    r_colour <= r_new_attack ? ATTACK_COLOUR : BODY_COLOUR;
                    if (w_last)
                        r_state <= ST_FINISH;
                end

                ST_FINISH: begin
                    r_done       <= 1'b1;
                    r_prev_x     <= r_new_x;
                    r_prev_valid <= r_new_valid && !r_new_dead;
                    r_state      <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase

            // Requests arriving while busy collapse into a single deferred redraw.
            if ((r_state != ST_IDLE) && bus.update)
                r_pending <= 1'b1;
        end
    end

    assign bus.vga_x  = r_vga_x;
    assign bus.vga_y  = r_vga_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_enemy_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_sprite_drawer
// Purpose  : Randomised scoreboard bench for enemy_sprite_drawer.
// Revision : 1.0
// ============================================================================
module tb_enemy_sprite_drawer;

    localparam int W  = 16;
    localparam int H  = 24;
    localparam int YT = 8;

    typedef struct {
        int cyc;
        bit is_done;
        int x;
        int y;
        int col;
    } exp_t;

    logic clk;
    logic rst;
    enemy_sprite_drawer_if bus ();

    enemy_sprite_drawer dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t q[$];

    bit m_started    = 0;
    bit m_rst_edge   = 0;
    bit m_prev_valid = 0;
    int m_prev_x     = 0;
    bit m_pending    = 0;
    int m_start      = 0;
    int m_end        = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void push_box(input int bx, input int c, inout int k);
        for (int r = 0; r < H; r++)
            for (int cc = 0; cc < W; cc++) begin
                k++;
                q.push_back('{k, 1'b0, bx + cc, YT + r, c});
            end
    endfunction

    // Reference model: a redraw is a list of timestamped pixels plus a done event.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_rst_edge = rst;
            if (rst) begin
                m_started    = 1;
                q.delete();
                m_prev_valid = 0;
                m_prev_x     = 0;
                m_pending    = 0;
                m_start      = 0;
                m_end        = 0;
            end else if ((cyc > m_end) && (bus.update || m_pending)) begin
                int  k;
                int  nx;
                bit  drw;
                nx  = (bus.x_pos == 2'd0) ? 0 : 20 + 40 * (int'(bus.x_pos) - 1);
                drw = (bus.x_pos != 2'd0) && !bus.dead;
                m_pending = 0;
                m_start   = cyc;
                k         = cyc;
                if (m_prev_valid) push_box(m_prev_x, 0, k);
                if (drw) push_box(nx, bus.attack ? 6 : 4, k);
                k++;
                q.push_back('{k, 1'b1, 0, 0, 0});
                m_end        = k;
                m_prev_valid = drw;
                m_prev_x     = nx;
            end else if ((cyc <= m_end) && bus.update) begin
                m_pending = 1;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    initial begin
        forever begin
            bit exp_plot;
            bit exp_done;
            @(posedge clk);
            #1;
            if (m_started) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    chk("stale_expectation", q[0].cyc, cyc);
                    void'(q.pop_front());
                end
                exp_plot = (q.size() > 0) && !q[0].is_done && (q[0].cyc == cyc);
                exp_done = (q.size() > 0) && q[0].is_done && (q[0].cyc == cyc);
                chk("plot", int'(bus.plot), int'(exp_plot));
                chk("done", int'(bus.done), int'(exp_done));
                chk("busy", int'(bus.busy), int'((cyc > m_start) && (cyc <= m_end)));
                if (exp_plot) begin
                    if (bus.plot) begin
                        chk("vga_x", int'(bus.vga_x), q[0].x);
                        chk("vga_y", int'(bus.vga_y), q[0].y);
                        chk("colour", int'(bus.colour), q[0].col);
                    end
                    void'(q.pop_front());
                end else if (exp_done) begin
                    void'(q.pop_front());
                end
                if (m_rst_edge) begin
                    chk("reset_vga_x", int'(bus.vga_x), 0);
                    chk("reset_vga_y", int'(bus.vga_y), 0);
                    chk("reset_colour", int'(bus.colour), 0);
                end
            end
        end
    end

    task automatic pulse(input int x, input bit a, input bit d);
        @(negedge clk);
        bus.x_pos  = 2'(x);
        bus.attack = a;
        bus.dead   = d;
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2500 && !ok; i++) begin
            @(negedge clk);
            if ((cyc > m_end) && !m_pending && (q.size() == 0) && !bus.busy) ok = 1;
        end
        chk("idle_timeout", int'(ok), 1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.update = 1'b0;
        bus.x_pos  = 2'd0;
        bus.attack = 1'b0;
        bus.dead   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pulse(1, 0, 0); wait_idle();   // first draw, no erase
        pulse(3, 0, 0); wait_idle();   // move left to right
        pulse(2, 1, 0); wait_idle();   // attack pose
        pulse(2, 0, 1); wait_idle();   // dead: erase only
        pulse(1, 0, 0); wait_idle();   // no erase after death

        // Several requests during DRAW merge into one redraw with the latest inputs
        pulse(2, 0, 0);
        repeat (500) @(negedge clk);
        pulse(1, 0, 0);
        repeat (10) @(negedge clk);
        pulse(3, 0, 0);
        repeat (5) @(negedge clk);
        pulse(3, 0, 0);
        wait_idle();

        // Reset around pixel 100 of an erase; the following redraw must not erase
        pulse(1, 0, 0);
        repeat (98) @(negedge clk);
        do_reset(1);
        repeat (3) @(negedge clk);
        pulse(2, 0, 0); wait_idle();

        for (int it = 0; it < 40; it++) begin
            pulse($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 900)) @(negedge clk);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enemy_sprite_drawer.md
# enemy_sprite_drawer

Consumer side of the enemy control outputs. The enemy controller produces position codes (`x_pos`), `attack` and `dead`. This block turns each position or pose update into a raster sequence of pixel writes for the VGA adapter: it erases the enemy's previous bounding box, then draws the new one. It sits between the enemy controller/datapath and the VGA adapter's `x`/`y`/`colour`/`plot` port.

## Interface
Parameters:
- `SPRITE_W`, default 16: sprite box width in pixels.
- `SPRITE_H`, default 24: sprite box height in pixels.
- `Y_TOP`, default 8: top row of the sprite box.
- `BG_COLOUR`, default 3'b000: erase colour.
- `BODY_COLOUR`, default 3'b100: calm pose colour.
- `ATTACK_COLOUR`, default 3'b110: attacking pose colour.

Ports:
- `clock`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `update`, in, 1: single-cycle request to redraw using the current `x_pos`/`attack`/`dead`.
- `x_pos`, in, 2: position code. 1→x=20, 2→x=60, 3→x=100, 0→no position.
- `attack`, in, 1: attacking pose.
- `dead`, in, 1: enemy dead; erase only.
- `vga_x`, out, 8: pixel column.
- `vga_y`, out, 7: pixel row.
- `colour`, out, 3: pixel colour.
- `plot`, out, 1: pixel write enable.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse when a redraw completes.

## Operation
- **FSM states:** IDLE, ERASE, DRAW, FINISH.
- **Acceptance:** in IDLE, `update` or `pending` causes acceptance.
  - On acceptance, latch `new_x` (decoded), `new_attack`, `new_dead`, and clear `pending`.
  - `new_x` decoding: 20, 60 or 100; code 0 marks the box invalid.
  - Next state is ERASE if `prev_valid`, else DRAW (if the new box is valid), else FINISH.
- **Pending updates:** `update` outside IDLE sets `pending` (one deep; extra requests merge). Inputs are sampled live at acceptance, so the latest values win.
- **ERASE:** raster over the box at `prev_x`, `Y_TOP`, column-fastest, one pixel per cycle, `colour=BG_COLOUR`.
  - After the last pixel, go to DRAW if the new box is valid and `!new_dead`; otherwise go to FINISH.
- **DRAW:** same raster at `new_x`.
  - `colour = new_attack ? ATTACK_COLOUR : BODY_COLOUR`.
  - After the last pixel: FINISH.
- **FINISH:** one cycle.
  - Assert `done`.
  - Update `prev_x ← new_x`.
  - Update `prev_valid ← (new box valid && !new_dead)`.
  - Go to IDLE.
- **Pixel addressing:**
  - `vga_x = base_x + col`, 8-bit, with no overflow for defaults (max 115).
  - `vga_y = Y_TOP + row`, 7-bit (max 31).
  - Width rule: `base_x + SPRITE_W ≤ 160` and `Y_TOP + SPRITE_H ≤ 120`; configurations violating this are illegal.

## Timing
- **Reset:** on the first edge with `reset=1`, all of the following clear, and `plot` is low from that edge:
  - outputs: `vga_x=0`, `vga_y=0`, `colour=0`, `plot=0`, `busy=0`, `done=0`
  - internal state: `pending=0`, `prev_valid=0`, `prev_x=0`, `col=row=0`, state=IDLE
- **Reset mid-raster:** abandons the raster with no further pixels; the next redraw skips ERASE.
- **Registered outputs:** `update` accepted at edge t gives the first `plot` pixel valid after edge t+1.
- **Cycle counts:** ERASE and DRAW each take exactly `SPRITE_W*SPRITE_H` cycles (384 for defaults), with `plot` continuously high.
  - One idle `plot=0` cycle is not inserted between ERASE and DRAW; pixels are back-to-back.
- **Full redraw latency:**
  - With a previous box: accept → `done` = 1 + 384 + 384 + 1 cycles.
  - Without a previous box: 1 + 384 + 1 cycles.
  - Dead (with a previous box): 1 + 384 + 1 cycles.
- **`done` and back-to-back requests:** `done` is high exactly in the FINISH cycle.
  - `update` in the FINISH cycle sets `pending`; it is accepted in the following IDLE cycle.
  - `update` in the same cycle as acceptance is absorbed by that acceptance and does not set `pending`.
- **`busy`:** rises the edge after acceptance and falls the edge after FINISH.

## Structure
- **Shared package `punchout_pkg`:**
  - position decode constants `X_LEFT=20`, `X_MID=60`, `X_RIGHT=100`
  - screen limits 160×120
  - the colour constants
  - FSM state encoding for this block
- **Sub-module `box_scanner`:**
  - inputs: `start` (which zeros the counters) and `step`
  - outputs: `col`, `row`, and a `last` flag on the final pixel
  - instantiated once and reused by ERASE and DRAW
- Top-level holds the FSM, latches and output registers.

## Test plan
- **First draw after reset:** `x_pos=1`, `attack=0`, pulse `update` → no erase; 384 pixels covering x 20..35, y 8..31, `colour=3'b100`; `done` 386 cycles after acceptance.
- **Move left→right:** `x_pos=3`, `update` → 384 pixels at x 20..35 with colour 0, then 384 pixels at x 100..115 with colour 3'b100; `done` at cycle 770.
- **Attack pose:** `x_pos=2`, `attack=1`, `update` → erase at x 100..115, then draw at x 60..75 with colour 3'b110.
- **Dead:** `dead=1`, `update` → erase of the previous box only; `done` at cycle 386; a following `update` with `x_pos=1`, `dead=0` does no erase.
- **Pending merge:** three `update` pulses mid-DRAW, with `x_pos` changed to 1 then 3 → exactly one further redraw, using `x_pos=3`, starting the cycle after FINISH.
- **Reset mid-ERASE:** assert `reset` at pixel 100 → `plot=0` from that edge; all outputs 0; the next `update` draws without erasing.
